obstacle_spawner: RTL and testbench



---
 rtl/obstacle_spawner.sv | 227 ++++++++++++++++++++++
 tb/tb_obstacle_spawner.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_spawner.sv
// ---------------------------------------------------------------------------
// obstacle_spawner
//
// Keeps the X position and height of the two obstacles. On each obstacle-step
// pulse it moves both obstacles one column left. An obstacle that reaches the
// left edge is respawned off-screen to the right. The respawn gap and the new
// height come from a free-running 16-bit LFSR.
//
// Ports
//   clk            in   system clock
//   resetn         in   asynchronous active-low reset
//   clear          in   synchronous reload of initial positions (game in MENU)
//   run            in   game is RUNNING
//   tick           in   one-cycle obstacle-step pulse
//   level[1:0]     in   difficulty; present only with SPAWNER_LEVEL_EN defined
//   obs1X, obs2X   out  obstacle left-edge X
//   obs1H, obs2H   out  obstacle height above ground
//   spawn1, spawn2 out  one-cycle pulse when that obstacle has been respawned
//   busy           out  high while respawning
//
// Optional feature macro: SPAWNER_LEVEL_EN. When it is defined, each level
// step shrinks the respawn gap by 8 columns, down to a floor of 16.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | after reset/clear; waits for run
// RUN     | moves obstacles on tick (or a held tick); traps X==0 into pend
// RESPAWN | respawns one pending obstacle per cycle, obs1 first
// ---------------------------------------------------------------------------
module obstacle_spawner #(
    parameter logic [15:0] SEED     = 16'hACE1,
    parameter int          INIT1_X  = 120,
    parameter int          INIT2_X  = 254,
    parameter int          INIT1_H  = 7,
    parameter int          INIT2_H  = 14,
    parameter int          SPAWN_X  = 160,
    parameter int          MIN_GAP  = 40,
    parameter int          GAP_BITS = 5,
    parameter int          MIN_H    = 7,
    parameter int          H_BITS   = 3
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clear,
    input  logic       run,
    input  logic       tick,
`ifdef SPAWNER_LEVEL_EN
    input  logic [1:0] level,
`endif
    output logic [7:0] obs1X,
    output logic [7:0] obs2X,
    output logic [7:0] obs1H,
    output logic [7:0] obs2H,
    output logic       spawn1,
    output logic       spawn2,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        RESPAWN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [7:0]  x1_q, x1_d, x2_q, x2_d;
    logic [7:0]  h1_q, h1_d, h2_q, h2_d;
    logic        pend1_q, pend1_d, pend2_q, pend2_d;
    logic        hold_q, hold_d;
    logic        sp1_q, sp1_d, sp2_q, sp2_d;

    logic [9:0]          gap_eff;
    logic [GAP_BITS-1:0] rnd_gap;
    logic [H_BITS-1:0]   rnd_h;
    logic [7:0]          other_x;
    logic [9:0]          sum_x;
    logic [7:0]          new_x;
    logic [7:0]          new_h;

    // Fibonacci LFSR for x^16+x^14+x^13+x^11+1, shifting right; taps are
    // bits 0,2,3,5. A nonzero seed never reaches the all-zero state.
    assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

`ifdef SPAWNER_LEVEL_EN
    logic [9:0] lvl_sub;
    assign lvl_sub = {5'b00000, level, 3'b000};
    always_comb begin
        if (10'(MIN_GAP) >= lvl_sub + 10'd16) begin
            gap_eff = 10'(MIN_GAP) - lvl_sub;
        end else begin
            gap_eff = 10'd16;
        end
    end
`else
    assign gap_eff = 10'(MIN_GAP);
`endif

    assign rnd_gap = lfsr_q[H_BITS+GAP_BITS-1:H_BITS];
    assign rnd_h   = lfsr_q[H_BITS-1:0];

    // The obstacle being serviced is obs1 whenever pend1 is set. When both
    // are pending, obs2 is serviced one cycle later and sees obs1's new X.
    assign other_x = pend1_q ? x2_q : x1_q;
    assign sum_x   = {2'b00, other_x} + gap_eff + 10'(rnd_gap);
    assign new_h   = 8'(MIN_H) + 8'(rnd_h);

    always_comb begin
        if (sum_x < 10'(SPAWN_X)) begin
            new_x = 8'(SPAWN_X);
        end else if (sum_x > 10'd255) begin
            new_x = 8'hFF;
        end else begin
            new_x = sum_x[7:0];
        end
    end

    always_comb begin
        state_d = state_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        h1_d    = h1_q;
        h2_d    = h2_q;
        pend1_d = pend1_q;
        pend2_d = pend2_q;
        hold_d  = hold_q;
        sp1_d   = 1'b0;
        sp2_d   = 1'b0;

        if (clear) begin
            x1_d    = 8'(INIT1_X);
            x2_d    = 8'(INIT2_X);
            h1_d    = 8'(INIT1_H);
            h2_d    = 8'(INIT2_H);
            pend1_d = 1'b0;
            pend2_d = 1'b0;
            hold_d  = 1'b0;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (run) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (run && (tick || hold_q)) begin
                        if (x1_q == 8'd0) begin
                            pend1_d = 1'b1;
                        end else begin
                            x1_d = x1_q - 8'd1;
                        end
                        if (x2_q == 8'd0) begin
                            pend2_d = 1'b1;
                        end else begin
                            x2_d = x2_q - 8'd1;
                        end
                        hold_d = 1'b0;
                    end
                    if (pend1_d || pend2_d) begin
                        state_d = RESPAWN;
                    end
                end
                RESPAWN: begin
                    if (pend1_q) begin
                        x1_d    = new_x;
                        h1_d    = new_h;
                        pend1_d = 1'b0;
                        sp1_d   = 1'b1;
                    end else if (pend2_q) begin
                        x2_d    = new_x;
                        h2_d    = new_h;
                        pend2_d = 1'b0;
                        sp2_d   = 1'b1;
                    end
                    // Only one tick is remembered across a respawn.
                    if (run && tick) begin
                        hold_d = 1'b1;
                    end
                    if (!pend1_d && !pend2_d) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            lfsr_q  <= SEED;
            x1_q    <= 8'(INIT1_X);
            x2_q    <= 8'(INIT2_X);
            h1_q    <= 8'(INIT1_H);
            h2_q    <= 8'(INIT2_H);
            pend1_q <= 1'b0;
            pend2_q <= 1'b0;
            hold_q  <= 1'b0;
            sp1_q   <= 1'b0;
            sp2_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            h1_q    <= h1_d;
            h2_q    <= h2_d;
            pend1_q <= pend1_d;
            pend2_q <= pend2_d;
            hold_q  <= hold_d;
            sp1_q   <= sp1_d;
            sp2_q   <= sp2_d;
        end
    end

    assign obs1X  = x1_q;
    assign obs2X  = x2_q;
    assign obs1H  = h1_q;
    assign obs2H  = h2_q;
    assign spawn1 = sp1_q;
    assign spawn2 = sp2_q;
    assign busy   = (state_q == RESPAWN);

endmodule

// File: tb/tb_obstacle_spawner.sv
module tb_obstacle_spawner;

    logic clk, resetn, clear, run, tick;
    logic [7:0] o1x [4];
    logic [7:0] o2x [4];
    logic [7:0] o1h [4];
    logic [7:0] o2h [4];
    logic       s1 [4];
    logic       s2 [4];
    logic       bz [4];

    int n_cmp, n_bad;

    // Four instances share the inputs; they differ only in start positions:
    // 0: defaults, 1: obs1 at edge / obs2 at 131, 2: obs1 at edge / obs2 at 251,
    // 3: both at the edge.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        obstacle_spawner #(
            .INIT1_X(g == 0 ? 120 : 0),
            .INIT2_X(g == 0 ? 254 : (g == 1 ? 131 : (g == 2 ? 251 : 0)))
        ) dut (
            .clk    (clk),
            .resetn (resetn),
            .clear  (clear),
            .run    (run),
            .tick   (tick),
`ifdef SPAWNER_LEVEL_EN
            .level  (2'b00),
`endif
            .obs1X  (o1x[g]),
            .obs2X  (o2x[g]),
            .obs1H  (o1h[g]),
            .obs2H  (o2h[g]),
            .spawn1 (s1[g]),
            .spawn2 (s2[g]),
            .busy   (bz[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int mx [4][2];
    int mh [4][2];
    bit mp [4][2];
    bit ms [4][2];
    bit mhold [4];
    int mmode [4];      // 0 idle, 1 running, 2 respawning
    int mlfsr;

    function automatic int ini_x(int k, int j);
        if (j == 0) return (k == 0) ? 120 : 0;
        case (k)
            0: return 254;
            1: return 131;
            2: return 251;
            default: return 0;
        endcase
    endfunction

    task automatic reload(int k);
        for (int j = 0; j < 2; j++) begin
            mx[k][j] = ini_x(k, j);
            mh[k][j] = (j == 0) ? 7 : 14;
            mp[k][j] = 0;
        end
        mhold[k] = 0;
        mmode[k] = 0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            reload(k);
            ms[k][0] = 0;
            ms[k][1] = 0;
        end
        mlfsr = 16'hACE1;
    endtask

    task automatic model_step(bit c, bit r, bit t);
        int j, o, nx;
        for (int k = 0; k < 4; k++) begin
            ms[k][0] = 0;
            ms[k][1] = 0;
            if (c) begin
                reload(k);
            end else if (mmode[k] == 0) begin
                if (r) mmode[k] = 1;
            end else if (mmode[k] == 1) begin
                if (r && (t || mhold[k])) begin
                    for (int q = 0; q < 2; q++) begin
                        if (mx[k][q] == 0) mp[k][q] = 1;
                        else mx[k][q] = mx[k][q] - 1;
                    end
                    mhold[k] = 0;
                end
                if (mp[k][0] || mp[k][1]) mmode[k] = 2;
            end else begin
                j = mp[k][0] ? 0 : 1;
                o = 1 - j;
                nx = mx[k][o] + 40 + ((mlfsr / 8) % 32);
                if (nx < 160) nx = 160;
                if (nx > 255) nx = 255;
                mx[k][j] = nx;
                mh[k][j] = 7 + (mlfsr % 8);
                mp[k][j] = 0;
                ms[k][j] = 1;
                if (r && t) mhold[k] = 1;
                if (!mp[k][0] && !mp[k][1]) mmode[k] = 1;
            end
        end
        // x^16+x^14+x^13+x^11+1: new MSB from bits 0,2,3,5, shift right
        mlfsr = (mlfsr / 2) + 32768 * ((mlfsr ^ (mlfsr / 4) ^ (mlfsr / 8) ^ (mlfsr / 32)) % 2);
    endtask

    function automatic logic [34:0] dut_vec(int k);
        return {o1x[k], o2x[k], o1h[k], o2h[k], s1[k], s2[k], bz[k]};
    endfunction

    function automatic logic [34:0] mdl_vec(int k);
        return {8'(mx[k][0]), 8'(mx[k][1]), 8'(mh[k][0]), 8'(mh[k][1]),
                ms[k][0], ms[k][1], (mmode[k] == 2)};
    endfunction

    task automatic cycle(input bit c, input bit r, input bit t);
        clear = c;
        run   = r;
        tick  = t;
        @(posedge clk);
        if (!resetn) model_reset();
        else model_step(c, r, t);
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_cmp++;
        if ({o1x[0], o2x[0], o1h[0], o2h[0], s1[0], s2[0], bz[0]} !==
            {8'd120, 8'd254, 8'd7, 8'd14, 3'b000}) begin
            n_bad++;
            $display("FAIL reset_inst0: got %h want %h", dut_vec(0),
                     {8'd120, 8'd254, 8'd7, 8'd14, 3'b000});
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (dut_vec(k) !== mdl_vec(k)) begin
                n_bad++;
                $display("FAIL reset inst%0d: got %h want %h", k, dut_vec(k), mdl_vec(k));
            end
        end
        resetn = 1'b1;
    endtask

    task automatic test_idle_lfsr();
        for (int i = 0; i < 100; i++) begin
            cycle(0, 0, 0);
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (dut_vec(k) !== mdl_vec(k)) begin
                    n_bad++;
                    $display("FAIL idle inst%0d: got %h want %h", k, dut_vec(k), mdl_vec(k));
                end
            end
        end
    endtask

    task automatic test_ticks();
        int spc;
        spc = 0;
        cycle(0, 0, 1);
        cycle(0, 1, 1);
        n_cmp++;
        if (o1x[0] !== 8'd120) begin
            n_bad++;
            $display("FAIL idle_tick: got %0d want 120", o1x[0]);
        end
        for (int i = 0; i < 50; i++) begin
            cycle(0, 1, (i % 10) == 0);
            if (s1[0] || s2[0]) spc++;
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (dut_vec(k) !== mdl_vec(k)) begin
                    n_bad++;
                    $display("FAIL ticks inst%0d: got %h want %h", k, dut_vec(k), mdl_vec(k));
                end
            end
        end
        n_cmp++;
        if ({o1x[0], o2x[0], 8'(spc)} !== {8'd115, 8'd249, 8'd0}) begin
            n_bad++;
            $display("FAIL five_ticks: got x1=%0d x2=%0d spawns=%0d want 115 249 0",
                     o1x[0], o2x[0], spc);
        end
    endtask

    task automatic test_respawn();
        int g1, h1, g2;
        cycle(1, 0, 0);
        cycle(0, 1, 0);
        cycle(0, 1, 1);
        n_cmp++;
        if ({o1x[1], bz[1], s1[1], bz[3]} !== {8'd0, 1'b1, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL edge_hold: got x1=%0d busy=%0d sp=%0d busyD=%0d want 0 1 0 1",
                     o1x[1], bz[1], s1[1], bz[3]);
        end
        g1 = (mlfsr / 8) % 32;
        h1 = mlfsr % 8;
        cycle(0, 1, 1);
        n_cmp++;
        if ({s1[1], o1x[1], o1h[1]} !== {1'b1, 8'(170 + g1), 8'(7 + h1)} ||
            o1h[1] < 8'd7 || o1h[1] > 8'd14) begin
            n_bad++;
            $display("FAIL spawn1_pos: got sp=%0d x=%0d h=%0d want 1 %0d %0d",
                     s1[1], o1x[1], o1h[1], 170 + g1, 7 + h1);
        end
        n_cmp++;
        if (o1x[2] !== 8'd255) begin
            n_bad++;
            $display("FAIL saturate: got %0d want 255", o1x[2]);
        end
        n_cmp++;
        if ({s1[3], s2[3], o1x[3], bz[3]} !== {1'b1, 1'b0, 8'd160, 1'b1}) begin
            n_bad++;
            $display("FAIL both_first: got sp1=%0d sp2=%0d x1=%0d busy=%0d want 1 0 160 1",
                     s1[3], s2[3], o1x[3], bz[3]);
        end
        g2 = (mlfsr / 8) % 32;
        cycle(0, 1, 0);
        n_cmp++;
        if ({s1[3], s2[3], o2x[3]} !== {1'b0, 1'b1, 8'(200 + g2)}) begin
            n_bad++;
            $display("FAIL both_second: got sp1=%0d sp2=%0d x2=%0d want 0 1 %0d",
                     s1[3], s2[3], o2x[3], 200 + g2);
        end
        n_cmp++;
        if ({o1x[1], o2x[1]} !== {8'(169 + g1), 8'd129}) begin
            n_bad++;
            $display("FAIL held_tick: got %0d %0d want %0d 129", o1x[1], o2x[1], 169 + g1);
        end
        cycle(0, 1, 0);
        n_cmp++;
        if ({o1x[3], o2x[3], o1x[0], o2x[0]} !== {8'd159, 8'(199 + g2), 8'd118, 8'd252}) begin
            n_bad++;
            $display("FAIL after_busy: got %0d %0d %0d %0d want 159 %0d 118 252",
                     o1x[3], o2x[3], o1x[0], o2x[0], 199 + g2);
        end
        for (int i = 0; i < 20; i++) begin
            cycle(0, 1, 0);
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (dut_vec(k) !== mdl_vec(k)) begin
                    n_bad++;
                    $display("FAIL respawn_tail inst%0d: got %h want %h", k, dut_vec(k), mdl_vec(k));
                end
            end
        end
    endtask

    task automatic test_freeze();
        int sx [4][2];
        for (int k = 0; k < 4; k++) begin
            sx[k][0] = mx[k][0];
            sx[k][1] = mx[k][1];
        end
        for (int i = 0; i < 10; i++) cycle(0, 0, 1);
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if ({o1x[k], o2x[k]} !== {8'(sx[k][0]), 8'(sx[k][1])}) begin
                n_bad++;
                $display("FAIL freeze inst%0d: got %0d %0d want %0d %0d",
                         k, o1x[k], o2x[k], sx[k][0], sx[k][1]);
            end
        end
    endtask

    task automatic test_clear();
        int g;
        for (int i = 0; i < 30; i++) begin
            cycle(0, 1, (i % 3) == 0);
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (dut_vec(k) !== mdl_vec(k)) begin
                    n_bad++;
                    $display("FAIL pre_clear inst%0d: got %h want %h", k, dut_vec(k), mdl_vec(k));
                end
            end
        end
        cycle(1, 1, 1);
        n_cmp++;
        if ({o1x[0], o2x[0], o1h[0], o2h[0], bz[0]} !== {8'd120, 8'd254, 8'd7, 8'd14, 1'b0}) begin
            n_bad++;
            $display("FAIL clear_init: got %h want %h",
                     {o1x[0], o2x[0], o1h[0], o2h[0], bz[0]}, {8'd120, 8'd254, 8'd7, 8'd14, 1'b0});
        end
        cycle(0, 0, 1);
        cycle(0, 1, 1);
        n_cmp++;
        if (o1x[0] !== 8'd120) begin
            n_bad++;
            $display("FAIL clear_idle: got %0d want 120", o1x[0]);
        end
        cycle(0, 1, 1);
        n_cmp++;
        if ({o1x[0], bz[1]} !== {8'd119, 1'b1}) begin
            n_bad++;
            $display("FAIL clear_run: got %0d busy=%0d want 119 1", o1x[0], bz[1]);
        end
        g = (mlfsr / 8) % 32;
        cycle(0, 1, 0);
        n_cmp++;
        if ({s1[1], o1x[1]} !== {1'b1, 8'(170 + g)}) begin
            n_bad++;
            $display("FAIL lfsr_kept: got sp=%0d x=%0d want 1 %0d", s1[1], o1x[1], 170 + g);
        end
    endtask

    task automatic test_reset_mid();
        cycle(1, 0, 0);
        cycle(0, 1, 0);
        cycle(0, 1, 1);
        n_cmp++;
        if (bz[3] !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_busy: got %0d want 1", bz[3]);
        end
        resetn = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (dut_vec(k) !== mdl_vec(k)) begin
                n_bad++;
                $display("FAIL mid_reset inst%0d: got %h want %h", k, dut_vec(k), mdl_vec(k));
            end
        end
        cycle(0, 1, 1);
        cycle(0, 1, 1);
        resetn = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cycle(0, 1, (i % 4) == 1);
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (dut_vec(k) !== mdl_vec(k)) begin
                    n_bad++;
                    $display("FAIL post_reset inst%0d: got %h want %h", k, dut_vec(k), mdl_vec(k));
                end
            end
        end
    endtask

    task automatic test_random();
        bit c, r, t;
        for (int i = 0; i < 3000; i++) begin
            c = ($urandom_range(0, 799) == 0);
            r = ($urandom_range(0, 9) != 0);
            t = ($urandom_range(0, 3) == 0);
            cycle(c, r, t);
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (dut_vec(k) !== mdl_vec(k)) begin
                    n_bad++;
                    $display("FAIL random inst%0d cyc%0d: got %h want %h",
                             k, i, dut_vec(k), mdl_vec(k));
                end
            end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        clear  = 1'b0;
        run    = 1'b0;
        tick   = 1'b0;
        resetn = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        test_reset();
        test_idle_lfsr();
        test_ticks();
        test_respawn();
        test_freeze();
        test_clear();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
